serdes_slot_scheduler: RTL and testbench
========================================

SERDES_SLOT_SCHEDULER -- requirements
Module: serdes_slot_scheduler

Interface
REQ-001 The block SHALL have parameter NSLOT, default 16, meaning the number of 64-bit SERDES slot words scanned; legal values are 2..16.
REQ-002 The block SHALL have parameter IDW, default 4, meaning the slot index width; it SHALL be at least ceil(log2(NSLOT)).
REQ-003 Port CLK, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 Port RESETN, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port DATA, input, 64*NSLOT bits: concatenated slot words, with slot k at bits [64k+63:64k].
REQ-006 Port ENABLE, input, NSLOT bits: per-slot include mask, sampled with DATA at snapshot.
REQ-007 Port START, input, 1 bit: single-cycle scan request.
REQ-008 Port ABORT, input, 1 bit: cancels a scan in progress.
REQ-009 Port BUSY, output, 1 bit: high from the snapshot cycle through the last scan cycle.
REQ-010 Port DONE, output, 1 bit: one-cycle pulse when the result outputs update.
REQ-011 Port TOTSUM, output, 29 bits: sum of WFMSUM (word bits 24:0) over enabled slots.
REQ-012 Port TDCTOT, output, 9 bits: sum of TDCNUM (word bits 62:58) over enabled slots.
REQ-013 Port ANYNOTPED, output, 1 bit: OR of word bit 63 over enabled slots.
REQ-014 Port MAXVAL, output, 21 bits: largest MAXWAVEFORM (word bits 49:29) among enabled slots.
REQ-015 Port MAXSLOT, output, IDW bits: slot index holding MAXVAL.
REQ-016 Port MAXVALID, output, 1 bit: set when at least one slot was enabled in the completed scan.

Function
REQ-017 The FSM SHALL have the states IDLE, SNAP, SCAN and FINISH.
REQ-018 In IDLE, START=1 SHALL move the FSM to SNAP on the next edge; START in any other state SHALL be ignored without queueing.
REQ-019 SNAP SHALL register all of DATA and ENABLE into an internal snapshot and clear the accumulators and the slot counter; all subsequent processing SHALL use only the snapshot.
REQ-020 SCAN SHALL process exactly one slot per cycle, in index order 0..NSLOT-1, with a slot counter that does not wrap; after slot NSLOT-1 the FSM SHALL go to FINISH.
REQ-021 For each enabled slot, SCAN SHALL add the zero-extended WFMSUM to the sum accumulator, add the zero-extended TDCNUM to the TDC accumulator, and OR bit 63 into the pedestal flag.
REQ-022 Max tracking: a slot SHALL replace the current max only if it is the first enabled slot or its value is strictly greater; on ties the lowest index SHALL win.
REQ-023 Disabled slots SHALL leave every accumulator unchanged.
REQ-024 FINISH SHALL copy the accumulators to the result outputs, pulse DONE for one cycle and return to IDLE; FINISH SHALL accept no START.
REQ-025 Latency: DONE SHALL be high exactly NSLOT+2 cycles after the edge that samples START (1 cycle SNAP, NSLOT cycles SCAN, 1 cycle FINISH).
REQ-026 BUSY SHALL be 1 in SNAP and SCAN and 0 in IDLE and FINISH.
REQ-027 Result outputs SHALL change only in FINISH and SHALL hold between scans.
REQ-028 If no slot is enabled, the results SHALL be TOTSUM=0, TDCTOT=0, ANYNOTPED=0, MAXVAL=0, MAXSLOT=0, MAXVALID=0.
REQ-029 The accumulator widths (29 and 9 bits) SHALL be sufficient for 16 full-scale slots, so no overflow can occur and no saturation logic SHALL exist.
REQ-030 ABORT=1 in SNAP or SCAN SHALL return the FSM to IDLE on the next edge with no DONE and no change to the outputs; ABORT in IDLE or FINISH SHALL have no effect.
REQ-031 If START and ABORT are both high in IDLE, ABORT SHALL have no effect and the scan SHALL start.

Reset
REQ-032 With RESETN=0 at a rising edge, the FSM SHALL enter IDLE and all outputs, accumulators, the counter and the snapshot SHALL clear to 0.
REQ-033 Reset mid-scan SHALL discard the scan with no DONE; after RESETN returns high the block SHALL accept a new START on the next cycle.

Verification (NSLOT=4)
REQ-034 Basic scan: WFMSUM = 10/20/30/40, MAXWAVEFORM = 5/9/3/9, TDCNUM = 1/2/3/4, all slots enabled, START -> DONE at cycle 6, TOTSUM=100, TDCTOT=10, MAXVAL=9, MAXSLOT=1, MAXVALID=1.
REQ-035 Masking: same data with ENABLE=4'b0100 -> TOTSUM=30, TDCTOT=3, MAXVAL=3, MAXSLOT=2; then ENABLE=0 -> all results 0 and MAXVALID=0.
REQ-036 Full scale: every field all-ones and ANYNOTPED set only in slot 3 -> TOTSUM=4*(2^25-1), TDCTOT=124, ANYNOTPED=1, MAXSLOT=0.
REQ-037 Snapshot coherence: DATA changes every cycle after START -> results match the values at the SNAP edge only; a START pulse during BUSY is ignored (exactly one DONE).
REQ-038 ABORT at SCAN slot 2 -> no DONE, outputs keep the previous results; RESETN=0 mid-scan -> all outputs 0 and no DONE.

Source files
------------

// File: rtl/serdes_slot_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : serdes_slot_scheduler_if
// Brief    : Bus bundle for the SERDES slot scheduler: snapshot inputs, scan
//            control and the registered scan results.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface serdes_slot_scheduler_if #(
  parameter int NSLOT = 16,
  parameter int IDW   = 4
) ();

  logic [64*NSLOT-1:0] DATA;
  logic [NSLOT-1:0]    ENABLE;
  logic                START;
  logic                ABORT;
  logic                BUSY;
  logic                DONE;
  logic [28:0]         TOTSUM;
  logic [8:0]          TDCTOT;
  logic                ANYNOTPED;
  logic [20:0]         MAXVAL;
  logic [IDW-1:0]      MAXSLOT;
  logic                MAXVALID;

  // Requester side: drives slot words and scan control, observes results.
  modport master (
    output DATA, ENABLE, START, ABORT,
    input  BUSY, DONE, TOTSUM, TDCTOT, ANYNOTPED, MAXVAL, MAXSLOT, MAXVALID
  );

  // Scheduler side.
  modport slave (
    input  DATA, ENABLE, START, ABORT,
    output BUSY, DONE, TOTSUM, TDCTOT, ANYNOTPED, MAXVAL, MAXSLOT, MAXVALID
  );

endinterface
`default_nettype wire

// File: rtl/serdes_slot_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : serdes_slot_scheduler
// Brief    : Snapshots NSLOT 64-bit slot words, then scans one slot per cycle
//            accumulating waveform sum, TDC count, pedestal flag and the
//            maximum waveform (lowest index wins ties). Results are published
//            together with a one-cycle DONE pulse.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module serdes_slot_scheduler #(
  parameter int NSLOT = 16,
  parameter int IDW   = 4
) (
  input logic                   CLK,
  input logic                   RESETN,
  serdes_slot_scheduler_if.slave bus
);

  localparam logic [IDW-1:0] c_last_slot = IDW'(NSLOT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNAP   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Snapshot of the slot words and include mask taken in SNAP.
  logic [64*NSLOT-1:0] snap_data_q, snap_data_d;
  logic [NSLOT-1:0]    snap_en_q,   snap_en_d;
  logic [IDW-1:0]      slot_q,      slot_d;

  // Running accumulators for the scan in progress.
  logic [28:0]    sum_q,     sum_d;
  logic [8:0]     tdc_q,     tdc_d;
  logic           ped_q,     ped_d;
  logic [20:0]    max_q,     max_d;
  logic [IDW-1:0] maxslot_q, maxslot_d;
  logic           maxvld_q,  maxvld_d;

  // Published results; only FINISH loads them.
  logic [28:0]    totsum_q,    totsum_d;
  logic [8:0]     tdctot_q,    tdctot_d;
  logic           anynotped_q, anynotped_d;
  logic [20:0]    maxval_q,    maxval_d;
  logic [IDW-1:0] maxslot_o_q, maxslot_o_d;
  logic           maxvalid_q,  maxvalid_d;
  logic           done_q,      done_d;

  // Current slot word and its include bit, selected by the slot counter.
  logic [64*NSLOT-1:0] w_shifted;
  logic [NSLOT-1:0]    w_en_bits;
  logic [63:0]         w_word;
  logic                w_en;
  logic [24:0]         w_wfm;
  logic [4:0]          w_tdc;
  logic [20:0]         w_mxw;
  logic                w_np;
  logic                w_unused_bits;

  assign w_shifted     = snap_data_q >> {slot_q, 6'd0};
  assign w_en_bits     = snap_en_q >> slot_q;
  assign w_word        = w_shifted[63:0];
  assign w_en          = w_en_bits[0];
  assign w_wfm         = w_word[24:0];
  assign w_mxw         = w_word[49:29];
  assign w_tdc         = w_word[62:58];
  assign w_np          = w_word[63];
  assign w_unused_bits = ^{w_shifted[64*NSLOT-1:64], w_en_bits[NSLOT-1:1],
                           w_word[57:50], w_word[28:25]};

  assign bus.BUSY      = (state_q == ST_SNAP) || (state_q == ST_SCAN);
  assign bus.DONE      = done_q;
  assign bus.TOTSUM    = totsum_q;
  assign bus.TDCTOT    = tdctot_q;
  assign bus.ANYNOTPED = anynotped_q;
  assign bus.MAXVAL    = maxval_q;
  assign bus.MAXSLOT   = maxslot_o_q;
  assign bus.MAXVALID  = maxvalid_q;

  // Next-state, snapshot, accumulator and result logic for the scan FSM.
  always_comb begin
    state_d     = state_q;
    snap_data_d = snap_data_q;
    snap_en_d   = snap_en_q;
    slot_d      = slot_q;
    sum_d       = sum_q;
    tdc_d       = tdc_q;
    ped_d       = ped_q;
    max_d       = max_q;
    maxslot_d   = maxslot_q;
    maxvld_d    = maxvld_q;
    totsum_d    = totsum_q;
    tdctot_d    = tdctot_q;
    anynotped_d = anynotped_q;
    maxval_d    = maxval_q;
    maxslot_o_d = maxslot_o_q;
    maxvalid_d  = maxvalid_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ABORT is irrelevant here, so START+ABORT still starts a scan.
        if (bus.START) begin
          state_d = ST_SNAP;
        end
      end

      ST_SNAP: begin
        if (bus.ABORT) begin
          state_d = ST_IDLE;
        end else begin
          snap_data_d = bus.DATA;
          snap_en_d   = bus.ENABLE;
          slot_d      = '0;
          sum_d       = '0;
          tdc_d       = '0;
          ped_d       = 1'b0;
          max_d       = '0;
          maxslot_d   = '0;
          maxvld_d    = 1'b0;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (bus.ABORT) begin
          state_d = ST_IDLE;
        end else begin
          if (w_en) begin
            // Widths cover 16 full-scale slots, so plain addition cannot wrap.
            sum_d = sum_q + 29'(w_wfm);
            tdc_d = tdc_q + 9'(w_tdc);
            ped_d = ped_q | w_np;
            // Strictly-greater replacement keeps the lowest index on ties.
            if (!maxvld_q || (w_mxw > max_q)) begin
              max_d     = w_mxw;
              maxslot_d = slot_q;
              maxvld_d  = 1'b1;
            end
          end
          // Counter parks on the last slot rather than wrapping.
          if (slot_q == c_last_slot) begin
            state_d = ST_FINISH;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end

      ST_FINISH: begin
        totsum_d    = sum_q;
        tdctot_d    = tdc_q;
        anynotped_d = ped_q;
        maxval_d    = max_q;
        maxslot_o_d = maxslot_q;
        maxvalid_d  = maxvld_q;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot, accumulator and result registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= ST_IDLE;
      snap_data_q <= '0;
      snap_en_q   <= '0;
      slot_q      <= '0;
      sum_q       <= '0;
      tdc_q       <= '0;
      ped_q       <= 1'b0;
      max_q       <= '0;
      maxslot_q   <= '0;
      maxvld_q    <= 1'b0;
      totsum_q    <= '0;
      tdctot_q    <= '0;
      anynotped_q <= 1'b0;
      maxval_q    <= '0;
      maxslot_o_q <= '0;
      maxvalid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_data_q <= snap_data_d;
      snap_en_q   <= snap_en_d;
      slot_q      <= slot_d;
      sum_q       <= sum_d;
      tdc_q       <= tdc_d;
      ped_q       <= ped_d;
      max_q       <= max_d;
      maxslot_q   <= maxslot_d;
      maxvld_q    <= maxvld_d;
      totsum_q    <= totsum_d;
      tdctot_q    <= tdctot_d;
      anynotped_q <= anynotped_d;
      maxval_q    <= maxval_d;
      maxslot_o_q <= maxslot_o_d;
      maxvalid_q  <= maxvalid_d;
      done_q      <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serdes_slot_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_serdes_slot_scheduler
// Brief    : Scoreboard bench for serdes_slot_scheduler (NSLOT=4): directed
//            scans plus randomized scans against a behavioural model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_serdes_slot_scheduler;

  localparam int NSLOT = 4;
  localparam int IDW   = 2;

  typedef struct packed {
    logic [28:0]    tot;
    logic [8:0]     tdc;
    logic           anp;
    logic [20:0]    mx;
    logic [IDW-1:0] ms;
    logic           mv;
  } res_t;

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;

  serdes_slot_scheduler_if #(.NSLOT(NSLOT), .IDW(IDW)) bus ();

  serdes_slot_scheduler #(.NSLOT(NSLOT), .IDW(IDW)) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  res_t held  = '0;
  res_t exp_q[$];
  int   exp_cyc_q[$];

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string tag, input res_t e);
    chk({tag, "_totsum"},    64'(bus.TOTSUM),    64'(e.tot));
    chk({tag, "_tdctot"},    64'(bus.TDCTOT),    64'(e.tdc));
    chk({tag, "_anynotped"}, 64'(bus.ANYNOTPED), 64'(e.anp));
    chk({tag, "_maxval"},    64'(bus.MAXVAL),    64'(e.mx));
    chk({tag, "_maxslot"},   64'(bus.MAXSLOT),   64'(e.ms));
    chk({tag, "_maxvalid"},  64'(bus.MAXVALID),  64'(e.mv));
  endtask

  function automatic logic [63:0] mk(input int wfm, input int mxw, input int tdc, input bit np);
    logic [63:0] w;
    w        = '0;
    w[24:0]  = 25'(wfm);
    w[49:29] = 21'(mxw);
    w[62:58] = 5'(tdc);
    w[63]    = np;
    return w;
  endfunction

  // Reference: totals by summation, max found first, then lowest index holding it.
  function automatic res_t model(input logic [64*NSLOT-1:0] d, input logic [NSLOT-1:0] en);
    res_t        r;
    int unsigned tot, tdc, best;
    bit          any;
    logic [63:0] w;
    r = '0; tot = 0; tdc = 0; best = 0; any = 0;
    for (int k = 0; k < NSLOT; k++) begin
      if (en[k]) begin
        w    = d[64*k +: 64];
        tot += 32'(w[24:0]);
        tdc += 32'(w[62:58]);
        if (w[63]) r.anp = 1'b1;
        if (32'(w[49:29]) > best) best = 32'(w[49:29]);
        any = 1'b1;
      end
    end
    r.tot = 29'(tot);
    r.tdc = 9'(tdc);
    if (any) begin
      r.mv = 1'b1;
      r.mx = 21'(best);
      for (int k = NSLOT - 1; k >= 0; k--) begin
        w = d[64*k +: 64];
        if (en[k] && (32'(w[49:29]) == best)) r.ms = IDW'(k);
      end
    end
    return r;
  endfunction

  function automatic logic [64*NSLOT-1:0] rand_data();
    logic [64*NSLOT-1:0] d;
    logic [63:0]         w;
    for (int k = 0; k < NSLOT; k++) begin
      w = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) w[49:29] = 21'($urandom_range(0, 3));
      d[64*k +: 64] = w;
    end
    return d;
  endfunction

  // Monitor: pops expectations on DONE, otherwise results must hold.
  always @(negedge CLK) begin
    res_t e;
    int   c;
    if (RESETN) begin
      if (bus.DONE) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got DONE=1 expected no DONE (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("done_latency", 64'(cyc), 64'(c));
          chk_out("done", e);
          held = e;
        end
      end else begin
        chk("hold_outputs", 64'(bus.TOTSUM ^ 29'(bus.TDCTOT) ^ 29'(bus.MAXVAL)),
            64'(held.tot ^ 29'(held.tdc) ^ 29'(held.mx)));
        chk("hold_flags", 64'({bus.ANYNOTPED, bus.MAXSLOT, bus.MAXVALID}),
            64'({held.anp, held.ms, held.mv}));
      end
    end
  end

  // One complete scan; extra_at injects an ignored START that many cycles after SNAP.
  task automatic run_scan(input logic [64*NSLOT-1:0] d, input logic [NSLOT-1:0] en,
                          input bit scramble, input bit abort_too, input int extra_at);
    int c0;
    @(negedge CLK);
    bus.DATA = d; bus.ENABLE = en; bus.START = 1'b1; bus.ABORT = abort_too;
    @(negedge CLK);
    bus.START = 1'b0; bus.ABORT = 1'b0;
    c0 = cyc;
    chk("busy_snap", 64'(bus.BUSY), 64'd1);
    exp_q.push_back(model(d, en));
    exp_cyc_q.push_back(c0 + NSLOT + 2);
    for (int i = 1; i <= NSLOT + 2; i++) begin
      @(negedge CLK);
      if (scramble) begin
        bus.DATA   = rand_data();
        bus.ENABLE = NSLOT'($urandom);
      end
      bus.START = (i == extra_at);
      if (i == NSLOT)     chk("busy_last_scan", 64'(bus.BUSY), 64'd1);
      if (i == NSLOT + 1) chk("busy_finish",    64'(bus.BUSY), 64'd0);
    end
    bus.START = 1'b0;
  endtask

  task automatic abort_scan(input logic [64*NSLOT-1:0] d, input logic [NSLOT-1:0] en);
    @(negedge CLK);
    bus.DATA = d; bus.ENABLE = en; bus.START = 1'b1;
    repeat (3) @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    chk("busy_after_abort", 64'(bus.BUSY), 64'd0);
    repeat (NSLOT + 3) @(negedge CLK);
    chk_out("after_abort", held);
  endtask

  task automatic reset_mid_scan(input logic [64*NSLOT-1:0] d);
    @(negedge CLK);
    bus.DATA = d; bus.ENABLE = '1; bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (2) @(negedge CLK);
    RESETN = 1'b0;
    @(posedge CLK);
    held = '0;
    @(negedge CLK);
    RESETN = 1'b1;
    chk("busy_after_reset", 64'(bus.BUSY), 64'd0);
    chk("done_after_reset", 64'(bus.DONE), 64'd0);
    chk_out("after_reset", '0);
  endtask

  logic [64*NSLOT-1:0] basic_d, full_d;

  initial begin
    bus.DATA = '0; bus.ENABLE = '0; bus.START = 1'b0; bus.ABORT = 1'b0;
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_busy", 64'(bus.BUSY), 64'd0);
    chk("reset_done", 64'(bus.DONE), 64'd0);
    chk_out("reset", '0);
    RESETN = 1'b1;

    basic_d = {mk(40, 9, 4, 0), mk(30, 3, 3, 0), mk(20, 9, 2, 0), mk(10, 5, 1, 0)};
    run_scan(basic_d, 4'b1111, 0, 0, 0);
    chk("basic_totsum",  64'(bus.TOTSUM),  64'd100);
    chk("basic_tdctot",  64'(bus.TDCTOT),  64'd10);
    chk("basic_maxval",  64'(bus.MAXVAL),  64'd9);
    chk("basic_maxslot", 64'(bus.MAXSLOT), 64'd1);

    run_scan(basic_d, 4'b0100, 0, 0, 0);
    chk("mask_totsum",  64'(bus.TOTSUM),  64'd30);
    chk("mask_maxslot", 64'(bus.MAXSLOT), 64'd2);
    run_scan(basic_d, 4'b0000, 0, 0, 0);
    chk("none_maxvalid", 64'(bus.MAXVALID), 64'd0);

    full_d = {64'hFFFF_FFFF_FFFF_FFFF, {3{64'h7FFF_FFFF_FFFF_FFFF}}};
    run_scan(full_d, 4'b1111, 0, 0, 0);
    chk("full_totsum",  64'(bus.TOTSUM),  64'd134217724);
    chk("full_tdctot",  64'(bus.TDCTOT),  64'd124);
    chk("full_anynp",   64'(bus.ANYNOTPED), 64'd1);
    chk("full_maxslot", 64'(bus.MAXSLOT), 64'd0);

    // Snapshot coherence with a START during BUSY, then a START during FINISH.
    run_scan(basic_d, 4'b1011, 1, 0, 2);
    run_scan(rand_data(), 4'b1111, 1, 0, NSLOT + 1);
    // START together with ABORT in IDLE still starts a scan.
    run_scan(rand_data(), 4'b0110, 0, 1, 0);

    abort_scan(full_d, 4'b1111);
    reset_mid_scan(full_d);
    run_scan(basic_d, 4'b1111, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      run_scan(rand_data(), NSLOT'($urandom), $urandom_range(0, 1) == 1, 0,
               int'($urandom_range(0, NSLOT + 1)));
    end

    repeat (4) @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
